// File: rtl/rr_grant_sched_4x16.sv
// Round-robin grant scheduler: 16 requesters share one 4x16 decoded select.
// Grants are held until done, request drop, or the hold limit expires.
module rr_grant_sched_4x16 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  gnt_idx,
  output logic        gnt_en,
  output logic [15:0] gnt,
  output logic        timeout,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam bit TO_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [0:0]       state;
  logic [3:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [3:0] pick;
  logic [3:0] k;
  logic       found;
  logic       rel_user;
  logic       rel_to;
  logic       rel;

  // First set request at or above ptr, wrapping 15 -> 0.
  always_comb begin
    pick  = '0;
    k     = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      k = ptr + 4'(i);
      if (!found && req[k]) begin
        pick  = k;
        found = 1'b1;
      end
    end
  end

  assign rel_user = done | ~req[gnt_idx];
  assign rel_to   = TO_EN && (hold_cnt == HOLD_LAST);
  assign rel      = rel_user | rel_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_en   <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt_idx  <= pick;
            gnt_en   <= 1'b1;
            hold_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (rel) begin
            gnt_en  <= 1'b0;
            ptr     <= gnt_idx + 4'd1;
            state   <= IDLE;
            // A limit hit only counts as timeout when nothing else released.
            timeout <= rel_to & ~rel_user;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt  = gnt_en ? (16'd1 << gnt_idx) : 16'h0000;
  assign busy = (state == BUSY);

endmodule

// File: doc/rr_grant_sched_4x16.md
Name: rr_grant_sched_4x16

Overview:
- Round-robin scheduler that shares one 4x16 decoded select resource among 16 requesters.
- Each cycle it owns the resource, it produces a 4-bit grant index plus enable, and the one-hot 16-bit select derived from them.
- It holds a grant until the owner releases it, drops its request, or exceeds a hold limit.
- It sits between the requester bank and the decoded select lines.

Parameters:
- MAX_HOLD, 16: maximum cycles one grant may be held. 0 disables the timeout. Legal range 0..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  16  request vector; bit i = requester i wants the resource
- done  in  1  owner releases the grant this cycle; ignored when gnt_en=0
- gnt_idx  out  4  index of the current owner (registered)
- gnt_en  out  1  grant valid (registered)
- gnt  out  16  one-hot select: 1<<gnt_idx when gnt_en=1, else 16'h0000
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit
- busy  out  1  high while in state BUSY (equals gnt_en)

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE, ptr=0, gnt_idx=0, gnt_en=0, gnt=0, timeout=0, busy=0, hold_cnt=0.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit of req scanning upward from ptr, wrapping 15->0.
  - Next edge: gnt_idx=selected, gnt_en=1, hold_cnt=0, state=BUSY.
  - Latency from req asserted to gnt_en high is 1 edge.
- State BUSY:
  - Grant is held and gnt_idx is stable; hold_cnt increments each cycle, saturating.
  - Release condition, evaluated each cycle, any of:
    - (a) done=1
    - (b) req[gnt_idx]=0
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
  - On release, at the next edge: gnt_en=0, ptr=gnt_idx+1 mod 16, state=IDLE.
  - gnt_idx keeps its last value while gnt_en=0; gnt is forced to 0.
- Fairness:
  - At least 1 idle cycle separates consecutive grants.
  - The releasing requester has lowest priority in the next arbitration.
  - Any continuously requesting requester is granted within 15 intervening grants.
- Timeout pulse:
  - timeout=1 for exactly one cycle, aligned with gnt_en falling, only when (c) is the sole cause.
  - If (c) coincides with done=1 or a request drop, the release is normal and timeout=0.
- Simultaneous events:
  - done and req drop in the same cycle produce a single release.
  - New requests arriving during BUSY are only considered at the next IDLE arbitration.
- Wrap-around:
  - ptr=15 releases to ptr=0.
  - Scan from ptr=14 with req=16'h0001 grants index 0.
- done while IDLE: no effect.
- gnt decode: combinational from the registered gnt_idx/gnt_en, glitch-free relative to clk.

Test Plan:
- Reset/idle: rst_n=0 then release with req=0.
  -> gnt_en=0, gnt=0, timeout=0 for 10 cycles.
- Single requester: req=16'h0020.
  -> 1 edge later gnt_idx=5, gnt=16'h0020.
  -> Pulse done: gnt_en=0 next edge, ptr=6.
- Round robin: req=16'h8101 held, done pulsed each grant.
  -> Grant order 0, 8, 15, 0, each separated by 1 idle cycle.
- Timeout: MAX_HOLD=4, req=16'h0004 held, done=0.
  -> gnt_en high exactly 4 cycles; timeout=1 on the cycle gnt_en falls; regrant of index 2 after 1 idle cycle.
- Simultaneous release: on the 4th held cycle assert done.
  -> Release occurs with timeout=0.
  -> Separately: drop req[idx] and assert done together, giving a single release and ptr=idx+1.
- Async reset mid-grant: grant idx 9 active, pulse rst_n low mid-cycle.
  -> gnt=0 and gnt_en=0 immediately without waiting for clk.
  -> After release with req=16'h0200, grant idx 9 again (ptr=0).
